// File: rtl/md_pkg.sv
// Shared op-code, state and latency definitions for the multiply/divide scheduler.
// MD_MADD_EN enables the madd-class ops as multiply-class operations.
package md_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   function automatic logic is_mult_class(input logic [3:0] op);
      logic r;
      r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_MADD_EN
      r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return r;
   endfunction

   function automatic logic is_div_class(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for the latched op; wr_en drops for a zero divisor.
// MD_MADD_EN adds the accumulate/subtract forms on top of {hi_in,lo_in}.
module md_arith
   import md_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        wr_en
);

   logic signed [63:0] sa, sb, prod_s;
   logic [63:0]        prod_u, acc, res;
   logic               b_nz;
   logic [31:0]        b_safe;
   logic signed [31:0] quot_s, rem_s;
   logic [31:0]        quot_u, rem_u;

   always_comb begin
      sa     = {{32{a[31]}}, a};
      sb     = {{32{b[31]}}, b};
      prod_s = sa * sb;
      prod_u = {32'd0, a} * {32'd0, b};
      b_nz   = (b != 32'd0);
      // Divide by a safe value so a zero divisor never produces X; the result is discarded anyway.
      b_safe = b_nz ? b : 32'd1;
      quot_s = $signed(a) / $signed(b_safe);
      rem_s  = $signed(a) % $signed(b_safe);
      quot_u = a / b_safe;
      rem_u  = a % b_safe;
      acc    = {hi_in, lo_in};
      res    = acc;
      wr_en  = 1'b0;
      case (op)
         OP_MULT:  begin res = prod_s;                         wr_en = 1'b1; end
         OP_MULTU: begin res = prod_u;                         wr_en = 1'b1; end
         OP_DIV:   begin res = {rem_s, quot_s};                wr_en = b_nz; end
         OP_DIVU:  begin res = {rem_u, quot_u};                wr_en = b_nz; end
`ifdef MD_MADD_EN
         OP_MADD:  begin res = acc + prod_s;                   wr_en = 1'b1; end
         OP_MADDU: begin res = acc + prod_u;                   wr_en = 1'b1; end
         OP_MSUB:  begin res = acc - prod_s;                   wr_en = 1'b1; end
         OP_MSUBU: begin res = acc - prod_u;                   wr_en = 1'b1; end
`endif
         default:  begin res = acc;                            wr_en = 1'b0; end
      endcase
      hi_out = res[63:32];
      lo_out = res[31:0];
   end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle HI/LO scheduler: latches the op at issue, counts latency, commits HI/LO.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module md_sched
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall,
   output logic        done
);

   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d;

   logic [31:0]       res_hi, res_lo;
   logic              res_wr;

   md_arith u_arith (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi_in  (hi_q),
      .lo_in  (lo_q),
      .hi_out (res_hi),
      .lo_out (res_lo),
      .wr_en  (res_wr)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_mult_class(md_op)) begin
                  state_d = ST_MULT;
                  cnt_d   = CNT_W'(MULT_CYCLES - 1);
                  op_d    = md_op;
                  a_d     = rs_val;
                  b_d     = rt_val;
               end else if (is_div_class(md_op)) begin
                  state_d = ST_DIV;
                  cnt_d   = CNT_W'(DIV_CYCLES - 1);
                  op_d    = md_op;
                  a_d     = rs_val;
                  b_d     = rt_val;
               end else if (md_op == OP_MTHI) begin
                  hi_d = rs_val;
               end else if (md_op == OP_MTLO) begin
                  lo_d = rs_val;
               end
            end
         end
         ST_MULT, ST_DIV: begin
            // Issue attempts while busy fall through here and are dropped.
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (res_wr) begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy  = (state_q != ST_IDLE);
   assign stall = d_is_md & (busy | (start & (is_mult_class(md_op) | is_div_class(md_op))));
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign done  = done_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched; expectations are hand-computed constants.
// Build with MD_MADD_EN defined to exercise the accumulate ops.
module tb_md_sched;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs_val, rt_val;
   logic        d_is_md;
   logic [31:0] hi, lo;
   logic        busy, stall, done;

   int n_checks = 0;
   int n_errors = 0;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .md_op   (md_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .d_is_md (d_is_md),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .stall   (stall),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue op, expect n busy cycles then a done pulse; inj>=0 fires an MTHI while busy.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input int inj, input logic exp_stall0);
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
      #1;
      chk({tag, "_stall_issue"}, {31'd0, stall}, {31'd0, exp_stall0});
      step();
      rs_val = 32'h5A5A5A5A;
      rt_val = 32'hA5A5A5A5;
      for (int i = 0; i < n; i++) begin
         if (i == inj) begin
            start  = 1'b1;
            md_op  = OP_MTHI;
            rs_val = 32'hDEADBEEF;
         end else begin
            start = 1'b0;
         end
         #1;
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
         chk({tag, "_stall_busy"}, {31'd0, stall}, {31'd0, d_is_md});
         step();
      end
      start = 1'b0;
      md_op = OP_NONE;
      #1;
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
      $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      md_op   = OP_NONE;
      rs_val  = 32'd0;
      rt_val  = 32'd0;
      d_is_md = 1'b0;
      step();
      step();
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      reset_n = 1'b1;
      step();

      run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, -1, 1'b0);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFFE);
      step();
      chk("mult_done_clr", {31'd0, done}, 32'd0);

      run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, -1, 1'b0);
      chk("multu_hi", hi, 32'h00000001);
      chk("multu_lo", lo, 32'hFFFFFFFE);
      step();

      d_is_md = 1'b1;
      run_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 3, 1'b1);
      chk("div_hi", hi, 32'hFFFFFFFF);
      chk("div_lo", lo, 32'hFFFFFFFD);
      d_is_md = 1'b0;
      step();
      chk("div_hold_hi", hi, 32'hFFFFFFFF);
      chk("div_hold_lo", lo, 32'hFFFFFFFD);

      run_op("divu0", OP_DIVU, 32'd7, 32'd0, 10, -1, 1'b0);
      chk("divu0_hi", hi, 32'hFFFFFFFF);
      chk("divu0_lo", lo, 32'hFFFFFFFD);
      step();

      start = 1'b1; md_op = OP_MTLO; rs_val = 32'h12345678;
      step();
      start = 1'b0;
      chk("mtlo_lo", lo, 32'h12345678);
      chk("mtlo_hi", hi, 32'hFFFFFFFF);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      chk("mtlo_done", {31'd0, done}, 32'd0);
      $display("txn mtlo -> hi=%h lo=%h", hi, lo);

      start = 1'b1; md_op = OP_MTHI; rs_val = 32'h0BADF00D;
      step();
      start = 1'b0;
      chk("mthi_hi", hi, 32'h0BADF00D);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      $display("txn mthi -> hi=%h lo=%h", hi, lo);

      start = 1'b1; md_op = OP_NONE; rs_val = 32'h55555555;
      step();
      md_op = 4'hF;
      step();
      start = 1'b0;
      chk("nop_hi", hi, 32'h0BADF00D);
      chk("nop_lo", lo, 32'h12345678);
      chk("nop_busy", {31'd0, busy}, 32'd0);
      $display("txn nop -> hi=%h lo=%h", hi, lo);

      start = 1'b1; md_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
      step();
      start = 1'b0;
      step();
      step();
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      step();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("abort_no_done", {31'd0, done}, 32'd0);
         chk("abort_idle", {31'd0, busy}, 32'd0);
      end
      $display("txn reset_abort -> hi=%h lo=%h", hi, lo);

      start = 1'b1; md_op = OP_MTLO; rs_val = 32'hFFFFFFFF;
      step();
      start = 1'b0;
      chk("pre_madd_lo", lo, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
      run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, -1, 1'b0);
      chk("maddu_hi", hi, 32'd1);
      chk("maddu_lo", lo, 32'd0);
      step();
      run_op("msub", OP_MSUB, 32'd2, 32'd3, 5, -1, 1'b0);
      chk("msub_hi", hi, 32'd0);
      chk("msub_lo", lo, 32'hFFFFFFFA);
      step();
      run_op("madd", OP_MADD, 32'hFFFFFFFF, 32'd1, 5, -1, 1'b0);
      chk("madd_hi", hi, 32'd0);
      chk("madd_lo", lo, 32'hFFFFFFF9);
      step();
`else
      start = 1'b1; md_op = OP_MADDU; rs_val = 32'd1; rt_val = 32'd1; d_is_md = 1'b1;
      #1;
      chk("maddu_off_stall", {31'd0, stall}, 32'd0);
      step();
      start = 1'b0; d_is_md = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("maddu_off_busy", {31'd0, busy}, 32'd0);
         chk("maddu_off_done", {31'd0, done}, 32'd0);
         step();
      end
      chk("maddu_off_hi", hi, 32'd0);
      chk("maddu_off_lo", lo, 32'hFFFFFFFF);
      $display("txn maddu_disabled -> hi=%h lo=%h", hi, lo);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
